// File: rtl/serial_addsub_ctrl.sv
// serial_addsub_ctrl
//   Bit-serial add/subtract sequencer built around a single full-adder slice.
//   It computes a+b or a-b (as a + ~b + 1) one bit per clock, LSB first, over
//   WIDTH clocks. The carry is held in a flop between bits.
//
//   Optional feature: define SERIAL_OVF_EN to add the signed overflow output.
//
// Ports
//   clk       in   1      clock, all state changes on posedge
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      operation request, sampled only in IDLE
//   op        in   1      0 = add, 1 = subtract; latched with start
//   a, b      in   WIDTH  operands; latched with start
//   busy      out  1      high while bits are being processed
//   done      out  1      one-cycle pulse when result/carryOut are updated
//   result    out  WIDTH  sum/difference, held until the next completion
//   carryOut  out  1      final carry; for subtract, 1 = no borrow
//   overflow  out  1      signed overflow (SERIAL_OVF_EN only)
module serial_addsub_ctrl #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
`ifdef SERIAL_OVF_EN
  output logic             overflow,
`endif
  output logic             carryOut
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] acc_next;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  // Full-adder slice operating on the current LSBs
  always_comb begin
    sum_bit    = op_a[0] ^ op_b[0] ^ carry;
    carry_next = maj3(op_a[0], op_b[0], carry);
    acc_next   = {sum_bit, acc[WIDTH-1:1]};
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_a     <= '0;
      op_b     <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      carryOut <= 1'b0;
`ifdef SERIAL_OVF_EN
      overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_a  <= a;
            // Subtract is a + ~b with carry-in of 1
            op_b  <= op ? ~b : b;
            carry <= op;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          op_a  <= op_a >> 1;
          op_b  <= op_b >> 1;
          acc   <= acc_next;
          carry <= carry_next;
          if (cnt == LAST_BIT) begin
            cnt      <= '0;
            state    <= DONE;
            result   <= acc_next;
            carryOut <= carry_next;
`ifdef SERIAL_OVF_EN
            // During the last bit, carry holds the carry into the MSB slice
            overflow <= carry ^ carry_next;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
